// File: rtl/dma_arb_pkg.sv
// ---------------------------------------------------------------------------
// dma_arb_pkg
// Shared types and constants for the DMA channel arbiter.
//   dma_arb_state_e  : arbiter FSM states (IDLE, RD, WR, RSP)
//   DMA_RW_READ/WRITE: per-channel direction encoding on ch_rw
//   DMA_TIMEOUT_DATA : read data returned on a watchdog abort
// ---------------------------------------------------------------------------
package dma_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RSP  = 2'd3
   } dma_arb_state_e;

   localparam logic        DMA_RW_READ      = 1'b0;
   localparam logic        DMA_RW_WRITE     = 1'b1;
   localparam logic [31:0] DMA_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage : dma_arb_pkg

// File: rtl/dma_rr_picker.sv
// ---------------------------------------------------------------------------
// dma_rr_picker
// Combinational round-robin picker. Returns the first set request bit found
// searching upward from ptr_i+1, wrapping modulo NUM_CH, so the channel at
// ptr_i itself has the lowest priority.
// Ports:
//   req_i  : request vector
//   ptr_i  : index of the last winner
//   gnt_o  : one-hot winner (all zero when no request)
//   idx_o  : winner index (0 when no request)
//   any_o  : at least one request is present
// ---------------------------------------------------------------------------
module dma_rr_picker #(
   parameter int unsigned  NUM_CH = 4,
   localparam int unsigned IDX_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [IDX_W-1:0]  ptr_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              any_o
);

   logic [IDX_W-1:0] cand;
   logic             found;

   // NOTE: every variable written in this block gets a default first, so no
   // path leaves one unassigned and no latch is inferred.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = IDX_W'((int'(ptr_i) + k) % NUM_CH);
         if (!found && req_i[cand]) begin
            found        = 1'b1;
            gnt_o[cand]  = 1'b1;
            idx_o        = cand;
         end
      end
   end

   assign any_o = |req_i;

endmodule : dma_rr_picker

// File: rtl/dma_chan_arbiter.sv
// ---------------------------------------------------------------------------
// dma_chan_arbiter
// Round-robin scheduler sharing the engine's single-beat read/write port
// between NUM_CH DMA channels, one transaction outstanding at a time.
// The winner's address/data/direction are latched at grant, so channel
// inputs may change freely once granted.
//
// Optional feature: define DMA_ARB_TIMEOUT_EN to enable a watchdog that
// aborts a transaction after TIMEOUT_CYC cycles in RD/WR, completing it with
// ch_err=1 and ch_rdata=DMA_TIMEOUT_DATA. Without it ch_err is tied 0.
//
// Ports:
//   ACLK, ARESETn         : clock, synchronous active-low reset
//   ch_req/ch_rw          : per-channel request and direction (1 = write)
//   ch_addr/ch_wdata      : flattened 32-bit fields, channel i at [32*i+:32]
//   ch_gnt/ch_done        : one-hot ownership / one-cycle completion pulse
//   ch_rdata/ch_err       : read data and abort flag, valid with ch_done
//   R_req/AR_ADDR/R_DATA/R_valid          : engine read port
//   W_req/AW_ADDR/W_DATA/W_done           : engine write port
// ---------------------------------------------------------------------------
module dma_chan_arbiter
   import dma_arb_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                 ACLK,
   input  logic                 ARESETn,
   input  logic [NUM_CH-1:0]    ch_req,
   input  logic [NUM_CH-1:0]    ch_rw,
   input  logic [NUM_CH*32-1:0] ch_addr,
   input  logic [NUM_CH*32-1:0] ch_wdata,
   output logic [NUM_CH-1:0]    ch_gnt,
   output logic [NUM_CH-1:0]    ch_done,
   output logic [31:0]          ch_rdata,
   output logic                 ch_err,
   output logic                 R_req,
   output logic [31:0]          AR_ADDR,
   input  logic [31:0]          R_DATA,
   input  logic                 R_valid,
   output logic                 W_req,
   output logic [31:0]          AW_ADDR,
   output logic [31:0]          W_DATA,
   input  logic                 W_done
);

   localparam int unsigned IDX_W = $clog2(NUM_CH);

   if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
      $error("dma_chan_arbiter: NUM_CH must be in 2..8");
   end
   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("dma_chan_arbiter: TIMEOUT_CYC must be at least 2");
   end

   dma_arb_state_e    state_q,  state_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [NUM_CH-1:0] gnt_q,    gnt_d;
   logic [31:0]       addr_q,   addr_d;
   logic [31:0]       wdata_q,  wdata_d;
   logic [31:0]       rdata_q,  rdata_d;

   logic [NUM_CH-1:0] pick_gnt;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_any;
   logic              timeout_abort;

   // Unpacked views of the flattened channel buses for indexed access.
   logic [31:0] ch_addr_a  [NUM_CH];
   logic [31:0] ch_wdata_a [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign ch_addr_a[i]  = ch_addr[32*i +: 32];
      assign ch_wdata_a[i] = ch_wdata[32*i +: 32];
   end

   dma_rr_picker #(
      .NUM_CH (NUM_CH)
   ) u_picker (
      .req_i (ch_req),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

`ifdef DMA_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

   logic [CNT_W-1:0] cnt_q;
   logic             err_q;
   logic             cnt_expired;

   assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   // A response arriving in the expiry cycle wins over the abort.
   assign timeout_abort = cnt_expired &&
                          (((state_q == RD) && !R_valid) ||
                           ((state_q == WR) && !W_done));

   // RD/WR are only entered from IDLE, so clearing outside RD/WR is the
   // same as clearing on entry.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if ((state_q == RD) || (state_q == WR)) cnt_q <= cnt_q + 1'b1;
         else                                    cnt_q <= '0;
         // High exactly in the RSP cycle that follows an abort.
         err_q <= timeout_abort;
      end
   end

   assign ch_err = err_q;
`else
   assign timeout_abort = 1'b0;
   assign ch_err        = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gnt_d    = gnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_d    = pick_gnt;
               rr_ptr_d = pick_idx;
               addr_d   = ch_addr_a[pick_idx];
               wdata_d  = ch_wdata_a[pick_idx];
               state_d  = (ch_rw[pick_idx] == DMA_RW_WRITE) ? WR : RD;
            end
         end
         RD: begin
            if (R_valid) begin
               rdata_d = R_DATA;
               state_d = RSP;
            end else if (timeout_abort) begin
               rdata_d = DMA_TIMEOUT_DATA;
               state_d = RSP;
            end
         end
         WR: begin
            if (W_done) begin
               state_d = RSP;
            end else if (timeout_abort) begin
               rdata_d = DMA_TIMEOUT_DATA;
               state_d = RSP;
            end
         end
         RSP: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q  <= IDLE;
         rr_ptr_q <= IDX_W'(NUM_CH - 1);
         gnt_q    <= '0;
         // NOTE: the data registers are reset too because they drive outputs
         // that must read zero straight out of reset.
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_q    <= gnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
      end
   end

   assign ch_gnt   = gnt_q;
   assign ch_done  = (state_q == RSP) ? gnt_q : '0;
   assign ch_rdata = rdata_q;
   assign R_req    = (state_q == RD);
   assign W_req    = (state_q == WR);
   assign AR_ADDR  = addr_q;
   assign AW_ADDR  = addr_q;
   assign W_DATA   = wdata_q;

endmodule : dma_chan_arbiter

// File: tb/tb_dma_chan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dma_chan_arbiter
// Self-checking bench for dma_chan_arbiter (NUM_CH=4, TIMEOUT_CYC=16).
// The bench plays both the channels and the engine; expected grants come
// from a round-robin model over a pending-request vector. The timeout
// scenario runs only when DMA_ARB_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_dma_chan_arbiter;

   localparam int NCH = 4;

   logic           ACLK = 1'b0;
   logic           ARESETn;
   logic [NCH-1:0] ch_req, ch_rw;
   logic [NCH*32-1:0] ch_addr, ch_wdata;
   logic [NCH-1:0] ch_gnt, ch_done;
   logic [31:0]    ch_rdata;
   logic           ch_err;
   logic           R_req, W_req, R_valid, W_done;
   logic [31:0]    AR_ADDR, AW_ADDR, W_DATA, R_DATA;

   int total = 0;
   int bad   = 0;

   // Channel model: pending requests plus per-channel fields.
   logic [31:0]    m_addr  [NCH];
   logic [31:0]    m_wdata [NCH];
   logic           m_rw    [NCH];
   logic [NCH-1:0] m_pend;
   int             last_win;

   typedef struct packed {
      logic           hung;
      logic [NCH-1:0] gnt;
      logic           is_wr;
      logic [31:0]    addr;
      logic [31:0]    wdata;
      logic           stable;
      logic [NCH-1:0] done;
      logic [31:0]    rdata;
      logic           err;
      logic           req_after;
      logic [NCH-1:0] gnt_after;
      logic [NCH-1:0] done_after;
   } obs_t;

   dma_chan_arbiter #(
      .NUM_CH      (NCH),
      .TIMEOUT_CYC (16)
   ) dut (
      .ACLK     (ACLK),
      .ARESETn  (ARESETn),
      .ch_req   (ch_req),
      .ch_rw    (ch_rw),
      .ch_addr  (ch_addr),
      .ch_wdata (ch_wdata),
      .ch_gnt   (ch_gnt),
      .ch_done  (ch_done),
      .ch_rdata (ch_rdata),
      .ch_err   (ch_err),
      .R_req    (R_req),
      .AR_ADDR  (AR_ADDR),
      .R_DATA   (R_DATA),
      .R_valid  (R_valid),
      .W_req    (W_req),
      .AW_ADDR  (AW_ADDR),
      .W_DATA   (W_DATA),
      .W_done   (W_done)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_reset();
      ARESETn = 1'b0;
      tick();
      tick();
      ARESETn = 1'b1;
      last_win = NCH - 1;
   endtask

   task automatic apply_model();
      for (int i = 0; i < NCH; i++) begin
         ch_addr[32*i +: 32]  = m_addr[i];
         ch_wdata[32*i +: 32] = m_wdata[i];
         ch_rw[i]             = m_rw[i];
      end
      ch_req = m_pend;
   endtask

   // Round-robin rule: first pending channel after the last winner.
   function automatic int model_pick(logic [NCH-1:0] pend, int last);
      for (int k = 1; k <= NCH; k++) begin
         if (pend[(last + k) % NCH]) return (last + k) % NCH;
      end
      return -1;
   endfunction

   // Engine responder: waits for a request, answers after lat cycles and
   // records what it saw. The served channel withdraws on its ch_done
   // unless keep_req is set.
   task automatic engine_txn(input int lat, input logic [31:0] rdat,
                             input bit keep_req, input bit spurious,
                             output obs_t o);
      int n;
      o = '0;
      n = 0;
      while (!(R_req || W_req) && n < 50) begin
         tick();
         n++;
      end
      if (!(R_req || W_req)) begin
         o.hung = 1'b1;
         return;
      end
      o.gnt    = ch_gnt;
      o.is_wr  = W_req;
      o.addr   = W_req ? AW_ADDR : AR_ADDR;
      o.wdata  = W_DATA;
      o.stable = 1'b1;
      for (int i = 0; i < lat; i++) begin
         if (spurious && i == 0) begin
            if (o.is_wr) R_valid = 1'b1;
            else         W_done  = 1'b1;
         end
         tick();
         R_valid = 1'b0;
         W_done  = 1'b0;
         if (o.is_wr) begin
            if (!W_req || R_req || AW_ADDR !== o.addr || W_DATA !== o.wdata || ch_gnt !== o.gnt) o.stable = 1'b0;
         end else begin
            if (!R_req || W_req || AR_ADDR !== o.addr || ch_gnt !== o.gnt) o.stable = 1'b0;
         end
      end
      if (o.is_wr) W_done = 1'b1;
      else begin
         R_valid = 1'b1;
         R_DATA  = rdat;
      end
      tick();
      R_valid = 1'b0;
      W_done  = 1'b0;
      R_DATA  = $urandom;
      o.done      = ch_done;
      o.rdata     = ch_rdata;
      o.err       = ch_err;
      o.req_after = R_req | W_req;
      if (!keep_req) ch_req = ch_req & ~ch_done;
      tick();
      o.gnt_after  = ch_gnt;
      o.done_after = ch_done;
   endtask

   task automatic test_reset();
      ARESETn  = 1'b0;
      ch_req   = 4'b1111;
      ch_rw    = 4'($urandom);
      ch_addr  = {$urandom, $urandom, $urandom, $urandom};
      ch_wdata = {$urandom, $urandom, $urandom, $urandom};
      R_valid  = 1'b1;
      W_done   = 1'b1;
      R_DATA   = 32'h1111_2222;
      tick(); tick(); tick();
      total++; if (ch_gnt !== 4'b0)    begin bad++; $display("FAIL reset_gnt: got %b want 0000", ch_gnt); end
      total++; if (ch_done !== 4'b0)   begin bad++; $display("FAIL reset_done: got %b want 0000", ch_done); end
      total++; if (ch_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", ch_rdata); end
      total++; if (ch_err !== 1'b0)    begin bad++; $display("FAIL reset_err: got %b want 0", ch_err); end
      total++; if ({R_req, W_req} !== 2'b00) begin bad++; $display("FAIL reset_req: got %b want 00", {R_req, W_req}); end
      total++; if ({AR_ADDR, AW_ADDR, W_DATA} !== 96'h0) begin bad++; $display("FAIL reset_engine_bus: got %h want 0", {AR_ADDR, AW_ADDR, W_DATA}); end
      ch_req  = 4'b0;
      R_valid = 1'b0;
      W_done  = 1'b0;
      ARESETn = 1'b1;
      last_win = NCH - 1;
      tick();
      // Responses in IDLE with nothing requested must be ignored.
      R_valid = 1'b1;
      W_done  = 1'b1;
      tick();
      R_valid = 1'b0;
      W_done  = 1'b0;
      total++; if ({R_req, W_req, ch_done} !== 6'b0) begin bad++; $display("FAIL idle_spurious: got req/done %b want 0", {R_req, W_req, ch_done}); end
      tick();
      total++; if ({ch_gnt, ch_done} !== 8'b0) begin bad++; $display("FAIL idle_spurious_late: got gnt/done %b want 0", {ch_gnt, ch_done}); end
   endtask

   task automatic test_single_read();
      obs_t o;
      ch_rw = 4'b0000;
      ch_addr[31:0] = 32'h0001_0040;
      ch_req = 4'b0001;
      tick();
      total++; if (R_req !== 1'b1) begin bad++; $display("FAIL rd_grant_latency: R_req=%b want 1", R_req); end
      total++; if (AR_ADDR !== 32'h0001_0040) begin bad++; $display("FAIL rd_addr: got %h want 00010040", AR_ADDR); end
      engine_txn(5, 32'h1234_5678, 1'b0, 1'b0, o);
      total++; if (o.gnt !== 4'b0001) begin bad++; $display("FAIL rd_gnt: got %b want 0001", o.gnt); end
      total++; if (o.stable !== 1'b1) begin bad++; $display("FAIL rd_stable: got %b want 1", o.stable); end
      total++; if (o.done !== 4'b0001) begin bad++; $display("FAIL rd_done: got %b want 0001", o.done); end
      total++; if (o.rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_rdata: got %h want 12345678", o.rdata); end
      total++; if (o.err !== 1'b0) begin bad++; $display("FAIL rd_err: got %b want 0", o.err); end
      total++; if (o.req_after !== 1'b0) begin bad++; $display("FAIL rd_req_drop: got %b want 0", o.req_after); end
      total++; if ({o.gnt_after, o.done_after} !== 8'b0) begin bad++; $display("FAIL rd_after: gnt/done %b want 0", {o.gnt_after, o.done_after}); end
      last_win = 0;
   endtask

   task automatic test_single_write();
      obs_t o;
      ch_rw = 4'b0100;
      ch_addr[32*2 +: 32]  = 32'h0002_0000;
      ch_wdata[32*2 +: 32] = 32'hCAFE_F00D;
      ch_req = 4'b0100;
      tick();
      total++; if ({W_req, R_req} !== 2'b10) begin bad++; $display("FAIL wr_grant_latency: W/R=%b want 10", {W_req, R_req}); end
      // A stray R_valid during the write must not complete it.
      engine_txn(3, 32'h0, 1'b0, 1'b1, o);
      total++; if (o.gnt !== 4'b0100) begin bad++; $display("FAIL wr_gnt: got %b want 0100", o.gnt); end
      total++; if (o.addr !== 32'h0002_0000) begin bad++; $display("FAIL wr_addr: got %h want 00020000", o.addr); end
      total++; if (o.wdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL wr_data: got %h want cafef00d", o.wdata); end
      total++; if (o.stable !== 1'b1) begin bad++; $display("FAIL wr_stable: got %b want 1", o.stable); end
      total++; if (o.done !== 4'b0100) begin bad++; $display("FAIL wr_done: got %b want 0100", o.done); end
      total++; if (o.done_after !== 4'b0) begin bad++; $display("FAIL wr_done_width: got %b want 0000", o.done_after); end
      total++; if (o.req_after !== 1'b0) begin bad++; $display("FAIL wr_req_drop: got %b want 0", o.req_after); end
      ch_rw = 4'b0;
      last_win = 2;
   endtask

   task automatic test_fairness();
      obs_t o;
      logic [NCH-1:0] prev;
      int exp;
      do_reset();
      for (int i = 0; i < NCH; i++) begin
         m_rw[i]    = 1'($urandom);
         m_addr[i]  = 32'h1000_0000 + 32'(i) * 32'h100;
         m_wdata[i] = $urandom;
      end
      m_pend = 4'b1111;
      apply_model();
      prev = '0;
      for (int t = 0; t < 8; t++) begin
         exp = model_pick(m_pend, last_win);
         engine_txn($urandom_range(0, 3), $urandom, 1'b1, 1'b0, o);
         total++; if (o.gnt !== (4'b0001 << exp)) begin bad++; $display("FAIL fair_gnt[%0d]: got %b want ch%0d", t, o.gnt, exp); end
         total++; if (o.addr !== m_addr[exp]) begin bad++; $display("FAIL fair_addr[%0d]: got %h want %h", t, o.addr, m_addr[exp]); end
         total++; if (o.gnt === prev) begin bad++; $display("FAIL fair_repeat[%0d]: got %b twice, want a different channel", t, o.gnt); end
         prev = o.gnt;
         last_win = exp;
      end
      ch_req = 4'b0;
      m_pend = 4'b0;
   endtask

   task automatic test_withdraw_latch();
      obs_t o;
      int busy;
      do_reset();
      ch_rw = 4'b0000;
      ch_addr[32*1 +: 32] = 32'h0005_1100;
      ch_addr[32*3 +: 32] = 32'h0005_3300;
      ch_req = 4'b1010;
      tick();
      total++; if (ch_gnt !== 4'b0010) begin bad++; $display("FAIL wd_gnt: got %b want 0010", ch_gnt); end
      // Post-grant changes to ch1 must be ignored; ch3 withdraws.
      ch_addr[32*1 +: 32]  = 32'h0BAD_0BAD;
      ch_wdata[32*1 +: 32] = $urandom;
      ch_rw[1]  = 1'b1;
      ch_req[3] = 1'b0;
      engine_txn(3, 32'h7777_0001, 1'b0, 1'b0, o);
      total++; if (o.addr !== 32'h0005_1100) begin bad++; $display("FAIL wd_latched_addr: got %h want 00051100", o.addr); end
      total++; if ({o.is_wr, o.stable} !== 2'b01) begin bad++; $display("FAIL wd_latched_dir: wr/stable %b want 01", {o.is_wr, o.stable}); end
      total++; if (o.done !== 4'b0010) begin bad++; $display("FAIL wd_done: got %b want 0010", o.done); end
      total++; if (o.rdata !== 32'h7777_0001) begin bad++; $display("FAIL wd_rdata: got %h want 77770001", o.rdata); end
      busy = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ch_gnt[3] || R_req || W_req) busy++;
      end
      total++; if (busy !== 0) begin bad++; $display("FAIL wd_ch3_granted: busy cycles %0d want 0", busy); end
      ch_req = 4'b0;
      ch_rw  = 4'b0;
      last_win = 1;
   endtask

   task automatic test_random();
      obs_t o;
      int exp, lat, c;
      logic [31:0] rdat;
      do_reset();
      m_pend = '0;
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < NCH; i++) begin
            if (!m_pend[i] && $urandom_range(0, 1) == 1) begin
               m_pend[i]  = 1'b1;
               m_rw[i]    = 1'($urandom);
               m_addr[i]  = $urandom;
               m_wdata[i] = $urandom;
            end
         end
         if (m_pend == '0) begin
            c = $urandom_range(0, NCH - 1);
            m_pend[c]  = 1'b1;
            m_rw[c]    = 1'($urandom);
            m_addr[c]  = $urandom;
            m_wdata[c] = $urandom;
         end
         apply_model();
         exp  = model_pick(m_pend, last_win);
         rdat = $urandom;
         lat  = $urandom_range(0, 4);
         engine_txn(lat, rdat, 1'b0, 1'($urandom), o);
         total++; if (o.hung !== 1'b0) begin bad++; $display("FAIL rnd_hung[%0d]: no request seen", t); end
         total++; if (o.gnt !== (4'b0001 << exp)) begin bad++; $display("FAIL rnd_gnt[%0d]: got %b want ch%0d (pend %b)", t, o.gnt, exp, m_pend); end
         total++; if (o.is_wr !== m_rw[exp]) begin bad++; $display("FAIL rnd_dir[%0d]: got %b want %b", t, o.is_wr, m_rw[exp]); end
         total++; if (o.addr !== m_addr[exp]) begin bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", t, o.addr, m_addr[exp]); end
         if (m_rw[exp]) begin
            total++; if (o.wdata !== m_wdata[exp]) begin bad++; $display("FAIL rnd_wdata[%0d]: got %h want %h", t, o.wdata, m_wdata[exp]); end
         end else begin
            total++; if (o.rdata !== rdat) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", t, o.rdata, rdat); end
         end
         total++; if (o.stable !== 1'b1) begin bad++; $display("FAIL rnd_stable[%0d]: got %b want 1", t, o.stable); end
         total++; if ({o.done, o.err} !== {4'b0001 << exp, 1'b0}) begin bad++; $display("FAIL rnd_done[%0d]: done/err %b want ch%0d/0", t, {o.done, o.err}, exp); end
         total++; if (o.done_after !== 4'b0) begin bad++; $display("FAIL rnd_done_width[%0d]: got %b want 0000", t, o.done_after); end
         last_win    = exp;
         m_pend[exp] = 1'b0;
      end
      m_pend = '0;
      apply_model();
   endtask

   task automatic test_midop_reset();
      obs_t o;
      ch_rw = 4'b0000;
      ch_addr[32*2 +: 32] = 32'h0003_0300;
      ch_req = 4'b0100;
      tick();
      total++; if ({R_req, ch_gnt} !== 5'b1_0100) begin bad++; $display("FAIL mr_pre: req/gnt %b want 1_0100", {R_req, ch_gnt}); end
      tick();
      tick();
      ARESETn = 1'b0;
      R_valid = 1'b1;
      R_DATA  = 32'h9999_9999;
      tick();
      R_valid = 1'b0;
      total++; if (R_req !== 1'b0) begin bad++; $display("FAIL mr_req: got %b want 0", R_req); end
      total++; if (ch_gnt !== 4'b0) begin bad++; $display("FAIL mr_gnt: got %b want 0000", ch_gnt); end
      total++; if (ch_done !== 4'b0) begin bad++; $display("FAIL mr_done: got %b want 0000", ch_done); end
      ch_addr[31:0] = 32'h0000_0A00;
      ch_req  = 4'b0101;
      ARESETn = 1'b1;
      engine_txn(2, 32'h4444_0000, 1'b0, 1'b0, o);
      total++; if (o.gnt !== 4'b0001) begin bad++; $display("FAIL mr_first_winner: got %b want 0001", o.gnt); end
      total++; if (o.done !== 4'b0001) begin bad++; $display("FAIL mr_first_done: got %b want 0001", o.done); end
      engine_txn(1, 32'h4444_0002, 1'b0, 1'b0, o);
      total++; if (o.gnt !== 4'b0100) begin bad++; $display("FAIL mr_second_winner: got %b want 0100", o.gnt); end
      total++; if (o.addr !== 32'h0003_0300) begin bad++; $display("FAIL mr_second_addr: got %h want 00030300", o.addr); end
      ch_req = 4'b0;
      last_win = 2;
   endtask

`ifdef DMA_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      ch_rw = 4'b0000;
      ch_addr[31:0] = 32'h0006_0000;
      ch_req = 4'b0001;
      tick();
      n = 0;
      while (R_req && n < 100) begin
         n++;
         tick();
      end
      total++; if (n !== 16) begin bad++; $display("FAIL to_cycles: R_req high %0d cycles want 16", n); end
      total++; if (ch_done !== 4'b0001) begin bad++; $display("FAIL to_done: got %b want 0001", ch_done); end
      total++; if (ch_err !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", ch_err); end
      total++; if (ch_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL to_rdata: got %h want deadbeef", ch_rdata); end
      ch_req = 4'b0;
      tick();
      total++; if ({ch_done, ch_err} !== 5'b0) begin bad++; $display("FAIL to_after: done/err %b want 0", {ch_done, ch_err}); end
      // Response in the expiry cycle wins.
      ch_addr[63:32] = 32'h0006_1000;
      ch_req = 4'b0010;
      tick();
      for (int i = 0; i < 15; i++) tick();
      R_valid = 1'b1;
      R_DATA  = 32'h5A5A_0001;
      tick();
      R_valid = 1'b0;
      total++; if ({ch_done, ch_err} !== 5'b0010_0) begin bad++; $display("FAIL to_race: done/err %b want 0010_0", {ch_done, ch_err}); end
      total++; if (ch_rdata !== 32'h5A5A_0001) begin bad++; $display("FAIL to_race_rdata: got %h want 5a5a0001", ch_rdata); end
      ch_req = 4'b0;
      tick();
   endtask
`endif

   initial begin
      ARESETn  = 1'b0;
      ch_req   = '0;
      ch_rw    = '0;
      ch_addr  = '0;
      ch_wdata = '0;
      R_DATA   = '0;
      R_valid  = 1'b0;
      W_done   = 1'b0;
      last_win = NCH - 1;
      test_reset();
      test_single_read();
      test_single_write();
      test_fairness();
      test_withdraw_latch();
      test_random();
      test_midop_reset();
`ifdef DMA_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_dma_chan_arbiter
